// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bundle between the MEM stage (master) and data_mem_ctrl
// (slave).
//   req_valid    master->slave  request present
//   req_ready    slave->master  controller can accept a request
//   req_we       master->slave  1 = write, 0 = read
//   req_size     master->slave  00 byte, 01 halfword, 10 word, 11 reserved
//   req_unsigned master->slave  reads: 1 = zero-extend, 0 = sign-extend
//   req_addr     master->slave  byte address
//   req_wdata    master->slave  right-aligned write data
//   rsp_valid    slave->master  one-cycle response pulse
//   rsp_rdata    slave->master  extended read data (0 for writes/errors)
//   rsp_err      slave->master  request rejected
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressable big-endian data memory with one outstanding request.
// Byte, halfword and word accesses; reads are sign/zero extended and answered
// READ_LAT cycles after acceptance, writes one cycle after acceptance.
// Misaligned, out-of-range and reserved-size requests answer with rsp_err.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (array contents are not cleared)
//   bus    data_mem_ctrl_if slave port (request/response bundle)
// Parameters: ADDR_W byte-address width (2^ADDR_W bytes), READ_LAT 1..4.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] hold_rdata;
    logic        hold_err;

    logic [7:0]  mem [0:(1 << ADDR_W) - 1];

    logic              accept;
    logic [32:0]       last_addr;
    logic [32:0]       span;
    logic              range_err;
    logic              align_err;
    logic              req_err;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       rd_ext;
    logic [31:0]       rsp_data;

    assign accept = bus.req_valid && bus.req_ready;

    // Request decode: error checks and the read snapshot, all evaluated
    // against the array as it is before the accepting edge.
    always_comb begin
        span = '0;
        case (bus.req_size)
            2'b01:   span = 33'd1;
            2'b10:   span = 33'd3;
            default: span = '0;
        endcase
        // Computed in 33 bits so a carry out of bit 31 also counts as out of range.
        last_addr = {1'b0, bus.req_addr} + span;
        range_err = |last_addr[32:ADDR_W];
        align_err = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_err   = (bus.req_size == 2'b11) || align_err || range_err;

        a0 = bus.req_addr[ADDR_W-1:0];
        a1 = a0 + ADDR_W'(1);
        a2 = a0 + ADDR_W'(2);
        a3 = a0 + ADDR_W'(3);
        b0 = mem[a0];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];

        rd_ext = '0;
        case (bus.req_size)
            2'b00:   rd_ext = bus.req_unsigned ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'b01:   rd_ext = bus.req_unsigned ? {16'd0, b0, b1} : {{16{b0[7]}}, b0, b1};
            2'b10:   rd_ext = {b0, b1, b2, b3};
            default: rd_ext = '0;
        endcase

        rsp_data = (bus.req_we || req_err) ? '0 : rd_ext;
    end

    // Array write path; no reset so committed data survives rst_n.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            case (bus.req_size)
                2'b00: mem[a0] <= bus.req_wdata[7:0];
                2'b01: begin
                    mem[a0] <= bus.req_wdata[15:8];
                    mem[a1] <= bus.req_wdata[7:0];
                end
                2'b10: begin
                    mem[a0] <= bus.req_wdata[31:24];
                    mem[a1] <= bus.req_wdata[23:16];
                    mem[a2] <= bus.req_wdata[15:8];
                    mem[a3] <= bus.req_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered handshake/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_rdata    <= '0;
            hold_err      <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        hold_rdata    <= rsp_data;
                        hold_err      <= req_err;
                        if (bus.req_we || READ_LAT == 1) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= rsp_data;
                            bus.rsp_err   <= req_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= 3'(READ_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        state         <= RESP;
                        cnt           <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= hold_rdata;
                        bus.rsp_err   <= hold_err;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl: one instance with READ_LAT=1 for the
// functional/error cases and one with READ_LAT=3 for latency, back-to-back
// and reset-during-WAIT behaviour. Both share clk and rst_n.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    data_mem_ctrl_if if1();
    data_mem_ctrl_if if3();

    data_mem_ctrl #(.ADDR_W(10), .READ_LAT(1)) u_lat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    data_mem_ctrl #(.ADDR_W(10), .READ_LAT(3)) u_lat3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input bit s3, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (s3) begin
            if3.req_valid = v; if3.req_we = we; if3.req_size = sz;
            if3.req_unsigned = uns; if3.req_addr = a; if3.req_wdata = wd;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
            if1.req_unsigned = uns; if1.req_addr = a; if1.req_wdata = wd;
        end
    endtask

    function automatic logic rdy(input bit s3);
        return s3 ? if3.req_ready : if1.req_ready;
    endfunction

    // One complete transaction, entered and left at a falling edge.
    task automatic xact(input string tag, input bit s3, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int          lat;
        int          w;
        logic [31:0] rd;
        logic        er;
        drive(s3, 1'b1, we, sz, uns, a, wd);
        w = 0;
        while (!rdy(s3) && w < 8) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) drive(s3, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
            if (s3 ? if3.rsp_valid : if1.rsp_valid) begin
                lat = n;
                rd  = s3 ? if3.rsp_rdata : if1.rsp_rdata;
                er  = s3 ? if3.rsp_err : if1.rsp_err;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);

        // Reset state
        repeat (3) begin
            @(negedge clk);
            chk("rst.vld1", 32'(if1.rsp_valid), 32'd0);
            chk("rst.rd1", if1.rsp_rdata, 32'd0);
            chk("rst.err1", 32'(if1.rsp_err), 32'd0);
            chk("rst.vld3", 32'(if3.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.rdy1", 32'(if1.req_ready), 32'd1);
        chk("rst.rdy3", 32'(if3.req_ready), 32'd1);

        // Word write then byte reads, big-endian order
        xact("wr_w10", 0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 1);
        xact("rd_b10", 0, 0, 2'b00, 1, 32'h10, 32'h0, 32'h11, 0, 1);
        xact("rd_b11", 0, 0, 2'b00, 1, 32'h11, 32'h0, 32'h22, 0, 1);
        xact("rd_b12", 0, 0, 2'b00, 1, 32'h12, 32'h0, 32'h33, 0, 1);
        xact("rd_b13", 0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h44, 0, 1);
        xact("wr_b11", 0, 1, 2'b00, 0, 32'h11, 32'hFFFFFF99, 32'h0, 0, 1);
        xact("rd_w10", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h11993344, 0, 1);

        // Sign/zero extension
        xact("wr_b20", 0, 1, 2'b00, 0, 32'h20, 32'h000000A5, 32'h0, 0, 1);
        xact("wr_b21", 0, 1, 2'b00, 0, 32'h21, 32'h00000080, 32'h0, 0, 1);
        xact("rd_b21s", 0, 0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0, 1);
        xact("rd_b21u", 0, 0, 2'b00, 1, 32'h21, 32'h0, 32'h00000080, 0, 1);
        xact("rd_h20u", 0, 0, 2'b01, 1, 32'h20, 32'h0, 32'h0000A580, 0, 1);
        xact("rd_h20s", 0, 0, 2'b01, 0, 32'h20, 32'h0, 32'hFFFFA580, 0, 1);

        // Error cases leave memory unchanged
        xact("wr_w00", 0, 1, 2'b10, 0, 32'h0, 32'h01020304, 32'h0, 0, 1);
        xact("wr_w3fc", 0, 1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 32'h0, 0, 1);
        xact("e_rdw02", 0, 0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 1, 1);
        xact("e_wrh03", 0, 1, 2'b01, 0, 32'h03, 32'h0000BEEF, 32'h0, 1, 1);
        xact("e_sz11", 0, 1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 1);
        xact("e_wrw3fe", 0, 1, 2'b10, 0, 32'h3FE, 32'h12345678, 32'h0, 1, 1);
        xact("e_rdb400", 0, 0, 2'b00, 1, 32'h400, 32'h0, 32'h0, 1, 1);
        xact("e_rdwtop", 0, 0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1);
        xact("rd_w00", 0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h01020304, 0, 1);
        xact("rd_w3fc", 0, 0, 2'b10, 0, 32'h3FC, 32'h0, 32'hCAFEF00D, 0, 1);

        // Top-of-memory accesses that are in range
        xact("rd_b3ff", 0, 0, 2'b00, 1, 32'h3FF, 32'h0, 32'h0000000D, 0, 1);
        xact("rd_h3feu", 0, 0, 2'b01, 1, 32'h3FE, 32'h0, 32'h0000F00D, 0, 1);
        xact("rd_h3fes", 0, 0, 2'b01, 0, 32'h3FE, 32'h0, 32'hFFFFF00D, 0, 1);

        // Read-after-write on the next accept edge
        xact("wr_w40", 0, 1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h0, 0, 1);
        xact("raw_w40", 0, 0, 2'b10, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1);

        // READ_LAT=3 instance
        xact("l3_wr80", 1, 1, 2'b10, 0, 32'h80, 32'h0BADF00D, 32'h0, 0, 1);
        xact("l3_rd80", 1, 0, 2'b10, 0, 32'h80, 32'h0, 32'h0BADF00D, 0, 3);

        // Back-to-back reads with req_valid held high
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80, '0);
        chk("b2b.rdy_a", 32'(if3.req_ready), 32'd1);
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h82, '0);
            chk("b2b.rdy_low1", 32'(if3.req_ready), 32'd0);
            chk("b2b.vld1", 32'(if3.rsp_valid), 32'(i == 3));
            if (i == 3) begin
                chk("b2b.rd1", if3.rsp_rdata, 32'h0BADF00D);
                chk("b2b.err1", 32'(if3.rsp_err), 32'd0);
            end
        end
        @(negedge clk);
        chk("b2b.rdy_b", 32'(if3.req_ready), 32'd1);
        chk("b2b.vld_off", 32'(if3.rsp_valid), 32'd0);
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
            chk("b2b.rdy_low2", 32'(if3.req_ready), 32'd0);
            chk("b2b.vld2", 32'(if3.rsp_valid), 32'(i == 3));
            if (i == 3) chk("b2b.rd2", if3.rsp_rdata, 32'h0000F00D);
        end

        // Reset while a read is waiting
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80, '0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
        chk("mrst.in_wait", 32'(if3.req_ready), 32'd0);
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("mrst.vld", 32'(if3.rsp_valid), 32'd0);
            chk("mrst.rd", if3.rsp_rdata, 32'd0);
            chk("mrst.err", 32'(if3.rsp_err), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst.rdy", 32'(if3.req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("mrst.no_rsp", 32'(if3.rsp_valid), 32'd0);
        end
        xact("mrst.rd80", 1, 0, 2'b10, 0, 32'h80, 32'h0, 32'h0BADF00D, 0, 3);
        xact("mrst.rd40", 0, 0, 2'b10, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
